load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_if.sv | 20 ++
 rtl/load_store_unit.sv | 160 ++++++++++++++++
 tb/tb_load_store_unit.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - memory request/response bus between the load/store unit and memory
interface load_store_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    input  bus_ready, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    output bus_ready, bus_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte/half/word load-store unit with bus timeout
module load_store_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic [2:0]              funct3,
  input  logic [31:0]             addr,
  input  logic [31:0]             wdata,
  output logic                    stall,
  output logic [31:0]             load_data,
  output logic                    load_valid,
  output logic                    misaligned,
  output logic                    bus_error,
  load_store_unit_if.master       bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  r_state;
  logic [7:0]  r_cnt;
  logic [31:0] r_bus_addr;
  logic [31:0] r_bus_wdata;
  logic [3:0]  r_bus_be;
  logic        r_bus_we;
  logic [2:0]  r_f3;
  logic [1:0]  r_off;
  logic        r_err;
  logic [31:0] r_load_data;

  logic        w_idle;
  logic        w_access;
  logic        w_size_ok;
  logic        w_aligned;
  logic        w_legal;
  logic        w_accept;
  logic [3:0]  w_be;
  logic [31:0] w_lanes;
  logic [31:0] w_shifted;
  logic [31:0] w_ext;
  logic        w_timeout;

  assign w_idle    = (r_state == S_IDLE);
  assign w_access  = mem_read | mem_write;
  assign w_legal   = (mem_read ^ mem_write) & w_size_ok & w_aligned;
  // rst_n gates the combinational outputs so they are quiet while reset is held
  assign w_accept  = rst_n & w_idle & w_access & w_legal;
  assign w_timeout = (r_cnt == 8'(TIMEOUT - 1));

  // Decode access size legality and alignment from funct3 and the low address bits
  always_comb begin
    w_size_ok = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b010: w_size_ok = 1'b1;
      3'b100, 3'b101:         w_size_ok = mem_read;
      default:                w_size_ok = 1'b0;
    endcase
    w_aligned = 1'b1;
    case (funct3[1:0])
      2'b01:   w_aligned = ~addr[0];
      2'b10:   w_aligned = (addr[1:0] == 2'b00);
      default: w_aligned = 1'b1;
    endcase
  end

  // Byte enables and replicated store lanes for the incoming request
  always_comb begin
    w_be    = 4'b1111;
    w_lanes = wdata;
    case (funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << addr[1:0];
        w_lanes = {4{wdata[7:0]}};
      end
      2'b01: begin
        w_be    = addr[1] ? 4'b1100 : 4'b0011;
        w_lanes = {2{wdata[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_lanes = wdata;
      end
    endcase
  end

  // Move the addressed lane of the read data down to bit 0 and extend it
  always_comb begin
    w_shifted = bus.bus_rdata >> {r_off, 3'b000};
    w_ext     = w_shifted;
    case (r_f3[1:0])
      2'b00:   w_ext = {{24{~r_f3[2] & w_shifted[7]}}, w_shifted[7:0]};
      2'b01:   w_ext = {{16{~r_f3[2] & w_shifted[15]}}, w_shifted[15:0]};
      default: w_ext = w_shifted;
    endcase
  end

  // Request FSM: latch on accept, wait for ready or timeout, one DONE cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= 8'd0;
      r_bus_addr  <= 32'd0;
      r_bus_wdata <= 32'd0;
      r_bus_be    <= 4'b0000;
      r_bus_we    <= 1'b0;
      r_f3        <= 3'd0;
      r_off       <= 2'd0;
      r_err       <= 1'b0;
      r_load_data <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state     <= S_REQ;
            r_cnt       <= 8'd0;
            r_bus_addr  <= {addr[31:2], 2'b00};
            r_bus_wdata <= w_lanes;
            r_bus_be    <= w_be;
            r_bus_we    <= mem_write;
            r_f3        <= funct3;
            r_off       <= addr[1:0];
            r_err       <= 1'b0;
          end
        end
        S_REQ: begin
          if (bus.bus_ready) begin
            r_state <= S_DONE;
            if (!r_bus_we) begin
              r_load_data <= w_ext;
            end
          end else if (w_timeout) begin
            r_state <= S_DONE;
            r_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.bus_req   = (r_state == S_REQ);
  assign bus.bus_we    = r_bus_we;
  assign bus.bus_addr  = r_bus_addr;
  assign bus.bus_wdata = r_bus_wdata;
  assign bus.bus_be    = r_bus_be;

  assign stall      = w_accept | (r_state == S_REQ);
  assign misaligned = rst_n & w_idle & w_access & ~w_legal;
  assign load_valid = (r_state == S_DONE) & ~r_bus_we & ~r_err;
  assign bus_error  = (r_state == S_DONE) & r_err;
  assign load_data  = r_load_data;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        misaligned;
  logic        bus_error;
  int          checks = 0;
  int          failures = 0;

  load_store_unit_if bus ();

  load_store_unit #(.TIMEOUT(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .stall      (stall),
    .load_data  (load_data),
    .load_valid (load_valid),
    .misaligned (misaligned),
    .bus_error  (bus_error),
    .bus        (bus.master)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h1000_0004;
    bus.bus_ready = 1'b1; bus.bus_rdata = 32'h1111_1111;
    settle;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b exp=0", stall); end
    checks++; if (bus.bus_req !== 1'b0) begin failures++; $display("FAIL reset_bus_req got=%0b exp=0", bus.bus_req); end
    checks++; if (bus.bus_be !== 4'b0000 || bus.bus_we !== 1'b0) begin failures++; $display("FAIL reset_be_we got=%b/%b exp=0000/0", bus.bus_be, bus.bus_we); end
    checks++; if (bus.bus_addr !== 32'd0 || bus.bus_wdata !== 32'd0) begin failures++; $display("FAIL reset_addr_wdata got=%h/%h exp=0/0", bus.bus_addr, bus.bus_wdata); end
    checks++; if (load_data !== 32'd0 || load_valid !== 1'b0 || bus_error !== 1'b0) begin failures++; $display("FAIL reset_load got=%h/%b/%b exp=0/0/0", load_data, load_valid, bus_error); end
    addr = 32'h1000_0002;
    #1;
    checks++; if (misaligned !== 1'b0) begin failures++; $display("FAIL reset_misaligned got=%0b exp=0", misaligned); end
    mem_read = 1'b0; addr = 32'd0;
    rst_n = 1'b1;
  endtask

  task automatic test_load(input string name, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] rdata, input logic [31:0] exp_addr,
                           input logic [3:0] exp_be, input logic [31:0] exp_data);
    tick;
    mem_read = 1'b1; mem_write = 1'b0; funct3 = f3; addr = a;
    bus.bus_ready = 1'b1; bus.bus_rdata = rdata;
    settle;
    checks++; if (stall !== 1'b1 || bus.bus_req !== 1'b0) begin failures++; $display("FAIL %s_accept stall/req got=%b/%b exp=1/0", name, stall, bus.bus_req); end
    tick;
    mem_read = 1'b0; addr = 32'hFFFF_FFFF; funct3 = 3'b111;
    settle;
    checks++; if (bus.bus_req !== 1'b1 || stall !== 1'b1 || bus.bus_we !== 1'b0) begin failures++; $display("FAIL %s_req req/stall/we got=%b/%b/%b exp=1/1/0", name, bus.bus_req, stall, bus.bus_we); end
    checks++; if (bus.bus_addr !== exp_addr) begin failures++; $display("FAIL %s_bus_addr got=%h exp=%h", name, bus.bus_addr, exp_addr); end
    checks++; if (bus.bus_be !== exp_be) begin failures++; $display("FAIL %s_bus_be got=%b exp=%b", name, bus.bus_be, exp_be); end
    tick;
    settle;
    checks++; if (load_valid !== 1'b1 || stall !== 1'b0 || bus.bus_req !== 1'b0) begin failures++; $display("FAIL %s_done valid/stall/req got=%b/%b/%b exp=1/0/0", name, load_valid, stall, bus.bus_req); end
    checks++; if (load_data !== exp_data) begin failures++; $display("FAIL %s_load_data got=%h exp=%h", name, load_data, exp_data); end
    tick;
    settle;
    checks++; if (load_valid !== 1'b0 || load_data !== exp_data) begin failures++; $display("FAIL %s_hold valid/data got=%b/%h exp=0/%h", name, load_valid, load_data, exp_data); end
    funct3 = 3'b000; addr = 32'd0;
  endtask

  task automatic test_store(input string name, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] exp_addr,
                            input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                            input logic [31:0] exp_ld);
    tick;
    mem_write = 1'b1; mem_read = 1'b0; funct3 = f3; addr = a; wdata = wd;
    bus.bus_ready = 1'b1; bus.bus_rdata = 32'h5555_5555;
    settle;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL %s_accept stall got=%b exp=1", name, stall); end
    tick;
    mem_write = 1'b0; wdata = 32'd0;
    settle;
    checks++; if (bus.bus_req !== 1'b1 || bus.bus_we !== 1'b1) begin failures++; $display("FAIL %s_req req/we got=%b/%b exp=1/1", name, bus.bus_req, bus.bus_we); end
    checks++; if (bus.bus_addr !== exp_addr || bus.bus_be !== exp_be) begin failures++; $display("FAIL %s_addr_be got=%h/%b exp=%h/%b", name, bus.bus_addr, bus.bus_be, exp_addr, exp_be); end
    checks++; if (bus.bus_wdata !== exp_wdata) begin failures++; $display("FAIL %s_wdata got=%h exp=%h", name, bus.bus_wdata, exp_wdata); end
    tick;
    settle;
    checks++; if (load_valid !== 1'b0 || stall !== 1'b0 || bus.bus_req !== 1'b0 || bus_error !== 1'b0) begin failures++; $display("FAIL %s_done valid/stall/req/err got=%b/%b/%b/%b exp=0/0/0/0", name, load_valid, stall, bus.bus_req, bus_error); end
    checks++; if (load_data !== exp_ld) begin failures++; $display("FAIL %s_load_data_kept got=%h exp=%h", name, load_data, exp_ld); end
  endtask

  task automatic test_misaligned(input string name, input logic rd, input logic wr,
                                 input logic [2:0] f3, input logic [31:0] a);
    tick;
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a;
    bus.bus_ready = 1'b1;
    settle;
    checks++; if (misaligned !== 1'b1 || stall !== 1'b0) begin failures++; $display("FAIL %s_pulse mis/stall got=%b/%b exp=1/0", name, misaligned, stall); end
    tick;
    mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000; addr = 32'd0;
    settle;
    checks++; if (misaligned !== 1'b0 || bus.bus_req !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL %s_after mis/req/stall got=%b/%b/%b exp=0/0/0", name, misaligned, bus.bus_req, stall); end
  endtask

  task automatic test_wait_states;
    int n_stall;
    bit seen;
    n_stall = 0; seen = 1'b0;
    tick;
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h1000_0008;
    bus.bus_ready = 1'b0; bus.bus_rdata = 32'h0123_4567;
    settle;
    if (stall === 1'b1) n_stall++;
    for (int k = 0; k < 20; k++) begin
      tick;
      mem_read = 1'b0;
      if (k == 2) bus.bus_ready = 1'b1;
      settle;
      if (load_valid === 1'b1) begin seen = 1'b1; break; end
      if (stall === 1'b1) n_stall++;
    end
    checks++; if (!seen) begin failures++; $display("FAIL wait_load_valid got=0 exp=1 within 20 cycles"); end
    checks++; if (n_stall != 4) begin failures++; $display("FAIL wait_stall_cycles got=%0d exp=4", n_stall); end
    checks++; if (load_data !== 32'h0123_4567) begin failures++; $display("FAIL wait_load_data got=%h exp=01234567", load_data); end
  endtask

  task automatic test_timeout;
    int n_req;
    n_req = 0;
    tick;
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h1000_0010;
    bus.bus_ready = 1'b0; bus.bus_rdata = 32'hAAAA_AAAA;
    settle;
    for (int k = 0; k < 40; k++) begin
      tick;
      mem_read = 1'b0;
      settle;
      if (bus.bus_req === 1'b1) n_req++;
      else break;
    end
    checks++; if (n_req != 16) begin failures++; $display("FAIL timeout_req_cycles got=%0d exp=16", n_req); end
    checks++; if (bus_error !== 1'b1 || load_valid !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL timeout_done err/valid/stall got=%b/%b/%b exp=1/0/0", bus_error, load_valid, stall); end
    checks++; if (load_data !== 32'h0123_4567) begin failures++; $display("FAIL timeout_load_data got=%h exp=01234567", load_data); end
    tick;
    settle;
    checks++; if (bus_error !== 1'b0 || bus.bus_req !== 1'b0) begin failures++; $display("FAIL timeout_idle err/req got=%b/%b exp=0/0", bus_error, bus.bus_req); end
  endtask

  task automatic test_reset_mid_req;
    bit pulse;
    pulse = 1'b0;
    tick;
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h1000_0004;
    bus.bus_ready = 1'b0;
    tick;
    mem_read = 1'b0;
    tick;
    tick;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.bus_req !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL midreset_drop req/stall got=%b/%b exp=0/0", bus.bus_req, stall); end
    for (int k = 0; k < 3; k++) begin
      tick;
      settle;
      if (load_valid !== 1'b0 || bus_error !== 1'b0 || misaligned !== 1'b0 || bus.bus_req !== 1'b0) pulse = 1'b1;
    end
    checks++; if (pulse) begin failures++; $display("FAIL midreset_no_pulse got=pulse exp=none"); end
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back;
    tick;
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h1000_0004;
    bus.bus_ready = 1'b1; bus.bus_rdata = 32'hCAFE_F00D;
    settle;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL b2b_accept1 stall got=%b exp=1", stall); end
    tick; settle;
    checks++; if (bus.bus_req !== 1'b1) begin failures++; $display("FAIL b2b_req1 got=%b exp=1", bus.bus_req); end
    tick; settle;
    checks++; if (load_valid !== 1'b1 || stall !== 1'b0 || load_data !== 32'hCAFE_F00D) begin failures++; $display("FAIL b2b_done1 valid/stall/data got=%b/%b/%h exp=1/0/cafef00d", load_valid, stall, load_data); end
    tick; settle;
    checks++; if (stall !== 1'b1 || bus.bus_req !== 1'b0) begin failures++; $display("FAIL b2b_accept2 stall/req got=%b/%b exp=1/0", stall, bus.bus_req); end
    tick;
    mem_read = 1'b0;
    settle;
    checks++; if (bus.bus_req !== 1'b1) begin failures++; $display("FAIL b2b_req2 got=%b exp=1", bus.bus_req); end
    tick; settle;
    checks++; if (load_valid !== 1'b1) begin failures++; $display("FAIL b2b_done2 got=%b exp=1", load_valid); end
  endtask

  initial begin
    bus.bus_ready = 1'b0;
    bus.bus_rdata = 32'd0;
    test_reset;
    test_load("lw",      3'b010, 32'h1000_0004, 32'hDEAD_BEEF, 32'h1000_0004, 4'b1111, 32'hDEAD_BEEF);
    test_load("lb3",     3'b000, 32'h1000_0003, 32'h8011_2233, 32'h1000_0000, 4'b1000, 32'hFFFF_FF80);
    test_load("lbu3",    3'b100, 32'h1000_0003, 32'h8011_2233, 32'h1000_0000, 4'b1000, 32'h0000_0080);
    test_load("lh2",     3'b001, 32'h1000_0002, 32'h8011_2233, 32'h1000_0000, 4'b1100, 32'hFFFF_8011);
    test_load("lhu2",    3'b101, 32'h1000_0002, 32'h8011_2233, 32'h1000_0000, 4'b1100, 32'h0000_8011);
    test_load("lb1",     3'b000, 32'h1000_0001, 32'h8011_2233, 32'h1000_0000, 4'b0010, 32'h0000_0022);
    test_load("lh0",     3'b001, 32'h1000_0000, 32'h1234_F00D, 32'h1000_0000, 4'b0011, 32'hFFFF_F00D);
    test_store("sh2", 3'b001, 32'h2000_0002, 32'h0000_ABCD, 32'h2000_0000, 4'b1100, 32'hABCD_ABCD, 32'hFFFF_F00D);
    test_store("sb1", 3'b000, 32'h2000_0001, 32'h1234_5678, 32'h2000_0000, 4'b0010, 32'h7878_7878, 32'hFFFF_F00D);
    test_store("sw",  3'b010, 32'h2000_0008, 32'h1234_5678, 32'h2000_0008, 4'b1111, 32'h1234_5678, 32'hFFFF_F00D);
    test_misaligned("lw_mis",  1'b1, 1'b0, 3'b010, 32'h1000_0002);
    test_misaligned("f3_011",  1'b1, 1'b0, 3'b011, 32'h1000_0000);
    test_misaligned("lh_odd",  1'b1, 1'b0, 3'b001, 32'h1000_0001);
    test_misaligned("rd_wr",   1'b1, 1'b1, 3'b010, 32'h1000_0000);
    test_misaligned("st_f3_4", 1'b0, 1'b1, 3'b100, 32'h1000_0000);
    test_wait_states;
    test_timeout;
    test_reset_mid_req;
    test_load("lw_after_rst", 3'b010, 32'h1000_0004, 32'hDEAD_BEEF, 32'h1000_0004, 4'b1111, 32'hDEAD_BEEF);
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
